// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// display_scan_ctrl : time-multiplexes buffered digit words onto one decoder
// Revision 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [5:0]                    wr_data,
    input  logic                          clr_err,
    output logic [5:0]                    dec_word,
    input  logic [6:0]                    dec_seg,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic [NUM_DIGITS-1:0]         err_flags,
    output logic [CNT_W-1:0]              err_count
);

    localparam int AW = $clog2(NUM_DIGITS);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [AW-1:0]    IDX_LAST  = AW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0]    SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [AW:0]      SLOTS     = (AW + 1)'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [4:0]       CODE_MAX  = 5'd19;

    logic [0:0]            state;
    logic [AW-1:0]         idx;
    logic [CW-1:0]         scan_cnt;
    logic [5:0]            bank [NUM_DIGITS];

    logic                  show;
    logic                  wr_take;
    logic                  addr_ok;
    logic                  word_err;
    logic [NUM_DIGITS-1:0] flags_nxt;
    logic [CNT_W-1:0]      count_nxt;

    // rst_n gating keeps outputs quiet while reset is asserted, before the edge
    assign show     = (state == ST_SHOW) && rst_n;
    assign wr_ready = show;
    assign seg      = show ? dec_seg : 7'd0;
    assign digit_en = show ? ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx) : '0;

    assign addr_ok  = ({1'b0, wr_addr} < SLOTS);
    assign wr_take  = wr_valid && wr_ready && addr_ok;
    assign word_err = (^wr_data) || (wr_data[5:1] > CODE_MAX);

    // A same-cycle write overrides the clear for its own slot and count
    always_comb begin
        flags_nxt = clr_err ? '0 : err_flags;
        count_nxt = clr_err ? '0 : err_count;
        if (wr_take) begin
            flags_nxt[wr_addr] = word_err;
            if (word_err && (count_nxt != CNT_MAX)) begin
                count_nxt = count_nxt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_BLANK;
            idx       <= '0;
            scan_cnt  <= '0;
            dec_word  <= 6'd0;
            err_flags <= '0;
            err_count <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                bank[i] <= 6'd0;
            end
        end else begin
            err_flags <= flags_nxt;
            err_count <= count_nxt;
            if (wr_take) begin
                bank[wr_addr] <= wr_data;
            end
            case (state)
                ST_BLANK: begin
                    dec_word <= bank[idx];
                    scan_cnt <= '0;
                    state    <= ST_SHOW;
                end
                default: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        state    <= ST_BLANK;
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
